mul_unit: RTL and testbench

Iterative 64×64 shift-add multiplier for the single-cycle datapath's MUL, UMULH and SMULH instructions. It sits directly downstream of the register file: it consumes operands from BusA and BusB and produces a 64-bit result that the writeback mux drives onto BusW. A Start/Busy/Done handshake lets the control unit stall the PC until Done.

---
 rtl/mul_unit.sv | 185 ++++++++++++++++++
 tb/tb_mul_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_unit.sv
// -----------------------------------------------------------------------------
// mul_unit -- iterative 64x64 shift-add multiplier (MUL / UMULH / SMULH)
//
// Sits between the register file (BusA/BusB) and the writeback mux (BusW).
// The control unit raises Start and stalls the PC until the Done pulse.
// One operation occupies the unit for 66 cycles:
//   accept edge -> 64 iterations -> FIN (sign fix, load Result) -> DONE.
//
// Ports
//   Clk      in   1   sole clock; all state changes on posedge
//   Reset_n  in   1   synchronous, active-low reset
//   Start    in   1   request a multiply (sampled only in IDLE)
//   Signed   in   1   1 = signed x signed (SMULH), 0 = unsigned
//   High     in   1   1 = product bits 127:64, 0 = bits 63:0
//   BusA     in  64   multiplicand
//   BusB     in  64   multiplier
//   Busy     out  1   operation in flight (RUN or FIN)
//   Done     out  1   one-cycle pulse, Result valid and updated
//   Result   out 64   registered product half, held until next completion
//
// Configuration macro: MUL_UNIT_HIGH_EN
//   defined   : 128-bit datapath, signed magnitude and sign-fix, High/Signed honoured
//   undefined : low-64-bit datapath only, High/Signed ignored, same timing
// -----------------------------------------------------------------------------
module mul_unit (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic        Signed,
  input  logic        High,
  input  logic [63:0] BusA,
  input  logic [63:0] BusB,
  output logic        Busy,
  output logic        Done,
  output logic [63:0] Result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [6:0]  r_cnt;
  logic [63:0] r_result;
  logic [63:0] w_res;
  logic        w_accept;
  logic        w_last;

  assign w_accept = (r_state == S_IDLE) && Start;
  assign w_last   = (r_cnt == 7'd63);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: reset is sampled on the clock edge (synchronous), so Reset_n only
  // appears inside the clocked branch, never in the sensitivity list.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: clocked state always uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block is defaulted first; without that, any
    // path that skips an assignment would infer a latch.
    w_state_nxt = r_state;
    Busy        = 1'b0;
    Done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        Busy = 1'b1;
        if (w_last) w_state_nxt = S_FIN;
      end
      S_FIN: begin
        Busy        = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        // Start here is ignored; the unit only accepts from IDLE.
        Done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef MUL_UNIT_HIGH_EN
  // ---------------------------------------------------------------------------
  // Full datapath: P[127:0] holds {partial sum, remaining multiplier bits}.
  // Operands are latched as magnitudes; the product sign is applied in FIN.
  // ---------------------------------------------------------------------------
  logic [127:0] r_p;
  logic [63:0]  r_a;
  logic         r_neg;
  logic         r_high;
  logic [63:0]  w_mag_a;
  logic [63:0]  w_mag_b;
  logic [64:0]  w_sum;
  logic [127:0] w_prod;

  // Negating 0x8000_0000_0000_0000 yields the same bit pattern, which read as
  // unsigned is exactly 2^63, so the magnitude never overflows.
  assign w_mag_a = (Signed && BusA[63]) ? (64'd0 - BusA) : BusA;
  assign w_mag_b = (Signed && BusB[63]) ? (64'd0 - BusB) : BusB;

  // 65-bit sum keeps the carry, which becomes P[127] after the shift.
  assign w_sum  = {1'b0, r_p[127:64]} + (r_p[0] ? {1'b0, r_a} : 65'd0);
  assign w_prod = r_neg ? (128'd0 - r_p) : r_p;
  assign w_res  = r_high ? w_prod[127:64] : w_prod[63:0];

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_cnt    <= 7'd0;
      r_p      <= 128'd0;
      r_a      <= 64'd0;
      r_neg    <= 1'b0;
      r_high   <= 1'b0;
      r_result <= 64'd0;
    end else if (w_accept) begin
      r_cnt  <= 7'd0;
      r_p    <= {64'd0, w_mag_b};
      r_a    <= w_mag_a;
      r_neg  <= Signed & (BusA[63] ^ BusB[63]);
      r_high <= High;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + 7'd1;
      r_p   <= {w_sum, r_p[63:1]};
    end else if (r_state == S_FIN) begin
      r_result <= w_res;
    end
  end

`else
  // ---------------------------------------------------------------------------
  // Low-only datapath: 64-bit accumulator, multiplicand shifts left while the
  // multiplier shifts right. High and Signed do not affect the low half.
  // ---------------------------------------------------------------------------
  logic [63:0] r_acc;
  logic [63:0] r_a;
  logic [63:0] r_b;
  logic        w_unused;

  assign w_unused = Signed ^ High;
  assign w_res    = r_acc;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_cnt    <= 7'd0;
      r_acc    <= 64'd0;
      r_a      <= 64'd0;
      r_b      <= 64'd0;
      r_result <= 64'd0;
    end else if (w_accept) begin
      r_cnt <= 7'd0;
      r_acc <= 64'd0;
      r_a   <= BusA;
      r_b   <= BusB;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + 7'd1;
      if (r_b[0]) r_acc <= r_acc + r_a;
      r_a <= {r_a[62:0], 1'b0};
      r_b <= {1'b0, r_b[63:1]};
    end else if (r_state == S_FIN) begin
      r_result <= w_res;
    end
  end
`endif

  assign Result = r_result;

endmodule

// File: tb/tb_mul_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_unit -- scoreboard bench for mul_unit.
// A driver issues operations and pushes the expected result (from a plain
// arithmetic reference model) into a queue; a monitor pops and compares on
// every Done pulse, and also checks latency, Busy length and pulse shape.
// -----------------------------------------------------------------------------
module tb_mul_unit;

  logic        Clk     = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start   = 1'b0;
  logic        Signed  = 1'b0;
  logic        High    = 1'b0;
  logic [63:0] BusA    = 64'd0;
  logic [63:0] BusB    = 64'd0;
  logic        Busy;
  logic        Done;
  logic [63:0] Result;

  mul_unit dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .Start  (Start),
    .Signed (Signed),
    .High   (High),
    .BusA   (BusA),
    .BusB   (BusB),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] exp;
    int          acc_cyc;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%h, required 0x%h", name, act, req);
    end
  endtask

  // Reference model: the architectural meaning of MUL/UMULH/SMULH.
  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic sgn, input logic hi);
`ifdef MUL_UNIT_HIGH_EN
    logic signed [127:0] sa;
    logic signed [127:0] sb;
    logic [127:0]        p;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      p  = sa * sb;
    end else begin
      p = {64'd0, a} * {64'd0, b};
    end
    return hi ? p[127:64] : p[63:0];
`else
    logic [63:0] p;
    p = a * b;
    if (sgn ^ hi) p = p;  // High and Signed do not change the low-only result
    return p;
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  int   busy_run  = 0;
  logic prev_done = 1'b0;
  exp_t mon_e;

  always @(negedge Clk) begin
    if (Reset_n === 1'b1) begin
      if (Busy && Done) check("busy_done_overlap", 64'd1, 64'd0);
      if (Done === 1'b1) begin
        if (prev_done) check("done_pulse_width", 64'd2, 64'd1);
        if (sb_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check(mon_e.name, Result, mon_e.exp);
          check({mon_e.name, "_latency"}, 64'(cyc - mon_e.acc_cyc), 64'd65);
          check({mon_e.name, "_busy_cycles"}, 64'(busy_run), 64'd65);
        end
      end
      prev_done = Done;
      busy_run  = (Busy === 1'b1) ? busy_run + 1 : 0;
    end else begin
      prev_done = 1'b0;
      busy_run  = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic wait_idle();
    int n = 0;
    while ((Busy !== 1'b0 || Done !== 1'b0) && n < 300) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 300) check("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic sgn,
                       input logic hi, input string name, input bit hold_start);
    exp_t e;
    int   n;
    wait_idle();
    Start  = 1'b1;
    Signed = sgn;
    High   = hi;
    BusA   = a;
    BusB   = b;
    @(posedge Clk);
    @(negedge Clk);
    e.exp     = model(a, b, sgn, hi);
    e.acc_cyc = cyc;
    e.name    = name;
    sb_q.push_back(e);
    check({name, "_busy_rise"}, 64'(Busy), 64'd1);
    if (hold_start) begin
      // Keep requesting a different operation for the whole run.
      BusA = 64'd9;
      BusB = 64'd9;
      n = 0;
      while (Done !== 1'b1 && n < 200) begin
        @(negedge Clk);
        n++;
      end
      Start = 1'b0;
      @(negedge Clk);
      check({name, "_no_reaccept"}, 64'(Busy), 64'd0);
    end else begin
      Start = 1'b0;
      BusA  = $urandom;
      BusB  = $urandom;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || Busy === 1'b1 || Done === 1'b1) && n < 300) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 300) check("drain_timeout", 64'd1, 64'd0);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0:       return 64'hFFFF_FFFF_FFFF_FFFF;
      1:       return 64'h8000_0000_0000_0000;
      2:       return 64'(($urandom_range(0, 15)));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    // Reset for two cycles and check the idle outputs.
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_done", 64'(Done), 64'd0);
    check("reset_result", Result, 64'd0);
    Reset_n = 1'b1;
    @(negedge Clk);

    do_op(64'd3, 64'd5, 1'b0, 1'b0, "mul_3x5", 1'b0);
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, "umulh_ff", 1'b0);
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, "mul_ff", 1'b0);
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b1, "smulh_m1x1", 1'b0);
    do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1, "smulh_min", 1'b0);
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, "smulh_m1xm1", 1'b0);
    do_op(64'd7, 64'd6, 1'b0, 1'b0, "start_busy_7x6", 1'b1);
    drain();

    // Reset in the middle of RUN: the operation is dropped silently.
    do_op(64'd10, 64'd11, 1'b0, 1'b0, "aborted", 1'b0);
    repeat (29) @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    check("midreset_busy", 64'(Busy), 64'd0);
    check("midreset_done", 64'(Done), 64'd0);
    check("midreset_result", Result, 64'd0);
    sb_q.delete();
    Reset_n = 1'b1;
    repeat (80) @(negedge Clk);
    check("midreset_quiet_busy", 64'(Busy), 64'd0);
    do_op(64'd2, 64'd2, 1'b0, 1'b0, "after_reset_2x2", 1'b0);
    drain();
    check("result_held", Result, 64'd4);

    // Randomised operations.
    for (int i = 0; i < 40; i++) begin
      do_op(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $sformatf("rand_%0d", i), 1'b0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
